// File: rtl/sd_cmd_ctrl.sv
// SD host command-path controller: issues a command frame to the physical layer,
// then waits for, captures and checks the response, or flags a timeout.
module sd_cmd_ctrl #(
  parameter int unsigned ARG_W       = 32,
  parameter int unsigned IDX_W       = 6,
  parameter int unsigned RSP_FRAME_W = 136,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                     clk_host,
  input  logic                     reset_host,
  input  logic                     new_command,
  input  logic [ARG_W-1:0]         cmd_argument,
  input  logic [IDX_W-1:0]         cmd_index,
  input  logic [1:0]               resp_type,
  input  logic                     phy_done,
  input  logic                     strobe_in,
  input  logic [RSP_FRAME_W-1:0]   cmd_in,
  output logic [RSP_FRAME_W-9:0]   response,
  output logic                     CMD_COMPLETE,
  output logic                     CMD_TIMEOUT,
  output logic                     CMD_INDEX_ERR,
  output logic                     strobe_out,
  output logic                     idle_out,
  output logic [IDX_W+ARG_W+1:0]   cmd_out
);

  localparam int unsigned RESP_W   = RSP_FRAME_W - 8;
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_PHY,
    WAIT_RESP,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   rsp_none_q, rsp_none_d;
  logic                   rsp_long_q, rsp_long_d;
  logic                   timeout_d, idx_err_d;
  logic [RESP_W-1:0]      response_d;
  logic [IDX_W+ARG_W+1:0] cmd_out_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rsp_none_d = rsp_none_q;
    rsp_long_d = rsp_long_q;
    timeout_d  = 1'b0;
    idx_err_d  = 1'b0;
    response_d = response;
    cmd_out_d  = cmd_out;
    case (state_q)
      IDLE: begin
        if (new_command) begin
          cmd_out_d  = {1'b0, 1'b1, cmd_index, cmd_argument};
          rsp_none_d = (resp_type == 2'b00);
          rsp_long_d = (resp_type == 2'b10);
          state_d    = SEND;
        end
      end
      SEND: state_d = WAIT_PHY;
      WAIT_PHY: begin
        if (phy_done) begin
          if (rsp_none_q) begin
            state_d = DONE;
          end else begin
            state_d = WAIT_RESP;
            cnt_d   = '0;
          end
        end
      end
      WAIT_RESP: begin
        // A frame arriving on the last counted cycle takes priority over the timeout.
        if (strobe_in) begin
          if (rsp_long_q) begin
            response_d = cmd_in[RSP_FRAME_W-1:8];
          end else begin
            response_d = RESP_W'(cmd_in[39:8]);
            idx_err_d  = (cmd_in[45:40] != 6'(cmd_out[ARG_W +: IDX_W]));
          end
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with state_q;
  // the status flags exist only for the single DONE cycle.
  always_ff @(posedge clk_host or negedge reset_host) begin
    if (!reset_host) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rsp_none_q    <= 1'b0;
      rsp_long_q    <= 1'b0;
      response      <= '0;
      cmd_out       <= '0;
      strobe_out    <= 1'b0;
      idle_out      <= 1'b1;
      CMD_COMPLETE  <= 1'b0;
      CMD_TIMEOUT   <= 1'b0;
      CMD_INDEX_ERR <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rsp_none_q    <= rsp_none_d;
      rsp_long_q    <= rsp_long_d;
      response      <= response_d;
      cmd_out       <= cmd_out_d;
      strobe_out    <= (state_d == SEND);
      idle_out      <= (state_d == IDLE);
      CMD_COMPLETE  <= (state_d == DONE);
      CMD_TIMEOUT   <= timeout_d;
      CMD_INDEX_ERR <= idx_err_d;
    end
  end

endmodule
